// File: rtl/fc_layer_sequencer.sv
// Layer-level sequencer: launches one data-mover pass per FC output node, writes each result to the output BRAM.
// Optional macro FC_RELU_EN: clamp negative (two's complement) results to zero before the BRAM write.
module fc_layer_sequencer #(
    parameter int unsigned CNT_BIT  = 31,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 12,
    parameter int unsigned NODE_BIT = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [NODE_BIT-1:0] num_out_i,
    input  logic [CNT_BIT-1:0]  run_count_i,
    input  logic                dm_idle_i,
    input  logic                dm_done_i,
    input  logic [DWIDTH-1:0]   dm_result_i,
    output logic                dm_start_o,
    output logic [CNT_BIT-1:0]  dm_run_count_o,
    output logic [AWIDTH-1:0]   dm_w_base_o,
    output logic [AWIDTH-1:0]   addr_o,
    output logic                ce_o,
    output logic                we_o,
    output logic [DWIDTH-1:0]   d_o,
    output logic                idle_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [NODE_BIT-1:0] node_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [NODE_BIT-1:0] num_out_q;
    logic [NODE_BIT-1:0] node_idx;
    logic [CNT_BIT-1:0]  run_count_q;
    logic [AWIDTH-1:0]   w_base;

    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   d_q;
    logic                ce_q;
    logic                we_q;
    logic                idle_q;
    logic                busy_q;
    logic                done_q;

    logic zero_layer_c;
    logic last_node_c;
    logic start_acc_c;
    logic advance_c;
    logic write_next_c;

    // Result post-processing applied on the way into the output BRAM.
    function automatic logic [DWIDTH-1:0] post_proc(input logic [DWIDTH-1:0] v);
`ifdef FC_RELU_EN
        return v[DWIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign zero_layer_c = (num_out_i == '0) || (run_count_i == '0);
    assign last_node_c  = (node_idx == (num_out_q - NODE_BIT'(1)));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort overrides every transition and suppresses the mover start.
    always_comb begin
        state_next = state;
        dm_start_o = 1'b0;
        if (abort_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state_next = zero_layer_c ? S_DONE : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (dm_idle_i) begin
                        dm_start_o = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dm_done_i) begin
                        state_next = S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_next = last_node_c ? S_DONE : S_LAUNCH;
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign start_acc_c  = (state == S_IDLE) && (state_next != S_IDLE);
    assign advance_c    = (state == S_WRITE) && (state_next == S_LAUNCH);
    assign write_next_c = (state_next == S_WRITE);

    // Layer parameters and per-node progress; counts stay latched after the layer for readback.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_out_q   <= '0;
            run_count_q <= '0;
            node_idx    <= '0;
            w_base      <= '0;
        end else if (start_acc_c) begin
            num_out_q   <= num_out_i;
            run_count_q <= run_count_i;
            node_idx    <= '0;
            w_base      <= '0;
        end else if (advance_c) begin
            node_idx    <= node_idx + NODE_BIT'(1);
            w_base      <= w_base + AWIDTH'(run_count_q);
        end
    end

    // Registered outputs decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            d_q    <= '0;
            ce_q   <= 1'b0;
            we_q   <= 1'b0;
            idle_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= write_next_c ? AWIDTH'(node_idx) : '0;
            d_q    <= write_next_c ? post_proc(dm_result_i) : '0;
            ce_q   <= write_next_c;
            we_q   <= write_next_c;
            idle_q <= (state_next == S_IDLE);
            busy_q <= (state_next == S_LAUNCH) || (state_next == S_WAIT) || (state_next == S_WRITE);
            done_q <= (state_next == S_DONE);
        end
    end

    assign dm_run_count_o = run_count_q;
    assign dm_w_base_o    = w_base;
    assign addr_o         = addr_q;
    assign ce_o           = ce_q;
    assign we_o           = we_q;
    assign d_o            = d_q;
    assign idle_o         = idle_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign node_idx_o     = node_idx;

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
Layer-level controller for the 4-core BRAM data mover in the fully connected datapath.
- Runs one data-mover pass per output node of an FC layer: pulses the mover's start, waits for its done, captures the summed MAC result.
- Writes each captured result to an output-node BRAM.
- Advances the weight base address between nodes.
- Sits between the host register file and the data mover / output BRAM.

Parameters:
CNT_BIT, 31, width of per-node word count (matches data mover run count)
DWIDTH, 32, data width of mover result and output BRAM
AWIDTH, 12, BRAM address width
NODE_BIT, 8, width of output-node count/index

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start_i  input  1  start layer; sampled in S_IDLE only
abort_i  input  1  synchronous abort, any state
num_out_i  input  NODE_BIT  number of output nodes; latched on accepted start
run_count_i  input  CNT_BIT  words per node; latched on accepted start
dm_idle_i  input  1  data mover idle status
dm_done_i  input  1  data mover done status (1-cycle pulse)
dm_result_i  input  DWIDTH  data mover summed result, valid while dm_done_i=1
dm_start_o  output  1  1-cycle start pulse to data mover
dm_run_count_o  output  CNT_BIT  latched run count to data mover
dm_w_base_o  output  AWIDTH  weight base address for current node
addr_o  output  AWIDTH  output BRAM address (= node index)
ce_o  output  1  output BRAM chip enable
we_o  output  1  output BRAM write enable
d_o  output  DWIDTH  output BRAM write data
idle_o  output  1  state == S_IDLE
busy_o  output  1  state in S_LAUNCH, S_WAIT, S_WRITE
done_o  output  1  state == S_DONE (1 cycle)
node_idx_o  output  NODE_BIT  current node index

Behaviour:
- Reset: state S_IDLE; all outputs 0 except idle_o=1. Internal node_idx, w_base, result_reg, latched counts = 0.
- States: S_IDLE, S_LAUNCH, S_WAIT, S_WRITE, S_DONE (registered 3-bit state).
- S_IDLE + start_i:
  - latch num_out_i and run_count_i; node_idx=0, w_base=0.
  - If either latched value is 0, go to S_DONE (no mover activity). Otherwise go to S_LAUNCH.
- S_LAUNCH:
  - if dm_idle_i=1: dm_start_o=1 for exactly this cycle, then go to S_WAIT.
  - if dm_idle_i=0: hold in S_LAUNCH with dm_start_o=0.
- S_WAIT: on dm_done_i=1, register dm_result_i into result_reg and go to S_WRITE. No timeout.
- S_WRITE (one cycle): ce_o=we_o=1, addr_o=node_idx[AWIDTH-1:0], d_o=result_reg (post optional ReLU).
  - If node_idx==num_out-1: go to S_DONE.
  - Else: node_idx+=1; w_base+=run_count (truncated to AWIDTH, wraps modulo 2^AWIDTH); go to S_LAUNCH.
- S_DONE: done_o=1 for one cycle, then go to S_IDLE. Latched counts are held for readback.
- Output-enable rules: ce_o/we_o/d_o are 0 outside S_WRITE. dm_run_count_o and dm_w_base_o are registered and stable from S_LAUNCH through S_WRITE.
- start_i is ignored outside S_IDLE.
- dm_done_i outside S_WAIT is ignored.
- abort_i has priority over all transitions: next state is S_IDLE, no write, no done_o, dm_start_o=0. A write already in progress in the abort cycle still completes. The data mover is not reset; the next start re-waits dm_idle_i in S_LAUNCH.
- Start-to-first-dm_start_o latency: 1 cycle (if mover idle).
- dm_done-to-write latency: 1 cycle.
- Node-to-next-launch: 2 cycles.
- Asynchronous reset mid-layer returns to the reset state immediately.

Optional Feature:
FC_RELU_EN
- Defined: result_reg is treated as signed two's complement; d_o = 0 when result_reg[DWIDTH-1]=1, else result_reg.
- Undefined: d_o = result_reg unmodified.

Test Plan:
1. num_out=3, run_count=4, mover model done 6 cycles after each start returning 10,20,30 -> three dm_start_o pulses; dm_w_base_o=0,4,8; BRAM writes addr0=10, addr1=20, addr2=30; done_o one cycle after last write.
2. num_out=0 or run_count=0 -> done_o asserted 1 cycle after start, no dm_start_o, no we_o.
3. dm_idle_i=0 for 5 cycles at launch -> dm_start_o held off, single pulse on first cycle dm_idle_i=1.
4. abort_i in S_WAIT of node 1 of 4 -> idle_o=1 next cycle; only addr0 written; no done_o; late dm_done_i ignored.
5. With FC_RELU_EN, results -5 (0xFFFFFFFB) and 7 -> writes 0 and 7. Without the macro -> writes 0xFFFFFFFB and 7.
6. run_count=3000, num_out=3 -> dm_w_base_o=0, 3000, 1904 (6000 mod 4096); start_i pulses mid-layer ignored.
